// File: rtl/spi_boot_master_if.sv
// Request/response bus between the FPGA boot-loader logic and spi_boot_master.
interface spi_boot_master_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          busy_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
  );
endinterface

// File: rtl/spi_boot_master.sv
// Single-lane mode-0 SPI master turning 32-bit write/read requests into
// 0x02 / 0x0B slave command frames for the boot loader.
module spi_boot_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  spi_boot_master_if.slave bus,
  output logic             spi_clk_o,
  output logic             spi_cs_o,
  output logic             spi_sdo0_o,
  input  logic             spi_sdi0_i
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MAX_BITS = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
  localparam int unsigned BIT_W    = $clog2(MAX_BITS);

  localparam logic [7:0]       CMD_WRITE  = 8'h02;
  localparam logic [7:0]       CMD_READ   = 8'h0B;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_CMD   = BIT_W'(7);
  localparam logic [BIT_W-1:0] LAST_WORD  = BIT_W'(31);
  localparam logic [BIT_W-1:0] LAST_DUMMY = BIT_W'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_HOLD, S_GUARD
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [BIT_W-1:0] bit_cnt, bit_n, slot_last;
  logic [31:0]      tx_sr, tx_n;
  logic [31:0]      rx_sr, rx_n;
  logic [31:0]      addr_q, addr_n;
  logic [31:0]      wdata_q, wdata_n;
  logic             write_q, write_n;
  logic             sdi_meta, sdi_sync;
  logic             ready_n, busy_n, rsp_valid_n;
  logic [31:0]      rdata_n;
  logic             sclk_n, cs_n, sdo_n;
  logic             div_last;
  logic [7:0]       cmd_sel;

  // tx_sr holds the bits still to be sent after the one currently on spi_sdo0_o
  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    bit_n       = bit_cnt;
    tx_n        = tx_sr;
    rx_n        = rx_sr;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    write_n     = write_q;
    ready_n     = bus.req_ready_o;
    busy_n      = bus.busy_o;
    rsp_valid_n = 1'b0;
    rdata_n     = bus.rsp_rdata_o;
    sclk_n      = spi_clk_o;
    cs_n        = spi_cs_o;
    sdo_n       = spi_sdo0_o;
    div_last    = (div_cnt == DIV_LAST);
    cmd_sel     = bus.req_write_i ? CMD_WRITE : CMD_READ;

    unique case (state)
      S_CMD:   slot_last = LAST_CMD;
      S_DUMMY: slot_last = LAST_DUMMY;
      default: slot_last = LAST_WORD;
    endcase

    unique case (state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          state_n = S_CMD;
          addr_n  = bus.req_addr_i;
          wdata_n = bus.req_wdata_i;
          write_n = bus.req_write_i;
          tx_n    = {cmd_sel[6:0], 25'h0};
          sdo_n   = cmd_sel[7];
          cs_n    = 1'b0;
          sclk_n  = 1'b0;
          div_n   = '0;
          bit_n   = '0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end

      S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA: begin
        div_n = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_n  = '0;
          sclk_n = ~spi_clk_o;
          // End of the high phase closes the bit slot
          if (spi_clk_o) begin
            bit_n = bit_cnt + BIT_W'(1);
            tx_n  = {tx_sr[30:0], 1'b0};
            sdo_n = tx_sr[31];
            if (state == S_RDATA) rx_n = {rx_sr[30:0], sdi_sync};
            if (bit_cnt == slot_last) begin
              bit_n = '0;
              unique case (state)
                S_CMD: begin
                  state_n = S_ADDR;
                  tx_n    = {addr_q[30:0], 1'b0};
                  sdo_n   = addr_q[31];
                end
                S_ADDR: begin
                  if (write_q) begin
                    state_n = S_WDATA;
                    tx_n    = {wdata_q[30:0], 1'b0};
                    sdo_n   = wdata_q[31];
                  end else begin
                    state_n = S_DUMMY;
                    tx_n    = '0;
                    sdo_n   = 1'b0;
                  end
                end
                S_DUMMY: begin
                  state_n = S_RDATA;
                  sdo_n   = 1'b0;
                end
                default: begin
                  state_n = S_HOLD;
                  sdo_n   = 1'b0;
                end
              endcase
            end
          end
        end
      end

      S_HOLD: begin
        div_n = div_cnt + DIV_W'(1);
        if (div_last) begin
          state_n     = S_GUARD;
          div_n       = '0;
          cs_n        = 1'b1;
          rsp_valid_n = 1'b1;
          rdata_n     = write_q ? 32'h0 : rx_sr;
        end
      end

      S_GUARD: begin
        div_n = div_cnt + DIV_W'(1);
        if (div_last) begin
          state_n = S_IDLE;
          div_n   = '0;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; MISO passes a 2-FF synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      write_q         <= 1'b0;
      sdi_meta        <= 1'b0;
      sdi_sync        <= 1'b0;
      bus.req_ready_o <= 1'b1;
      bus.busy_o      <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      spi_clk_o       <= 1'b0;
      spi_cs_o        <= 1'b1;
      spi_sdo0_o      <= 1'b0;
    end else begin
      state           <= state_n;
      div_cnt         <= div_n;
      bit_cnt         <= bit_n;
      tx_sr           <= tx_n;
      rx_sr           <= rx_n;
      addr_q          <= addr_n;
      wdata_q         <= wdata_n;
      write_q         <= write_n;
      sdi_meta        <= spi_sdi0_i;
      sdi_sync        <= sdi_meta;
      bus.req_ready_o <= ready_n;
      bus.busy_o      <= busy_n;
      bus.rsp_valid_o <= rsp_valid_n;
      bus.rsp_rdata_o <= rdata_n;
      spi_clk_o       <= sclk_n;
      spi_cs_o        <= cs_n;
      spi_sdo0_o      <= sdo_n;
    end
  end

endmodule

// File: tb/tb_spi_boot_master.sv
// Bench for spi_boot_master: SPI slave model plus frame-level reference checks
// on a CLK_DIV=2 instance (reads/writes) and a CLK_DIV=1 instance (writes).
module tb_spi_boot_master;

  localparam int unsigned DIV0 = 2;
  localparam int unsigned DUM0 = 32;
  localparam int unsigned DIV1 = 1;
  localparam int unsigned DUM1 = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        miso = 1'b0;

  logic sclk0, cs0, sdo0, sclk1, cs1, sdo1;

  spi_boot_master_if bus0 ();
  spi_boot_master_if bus1 ();

  assign bus0.req_valid_i = req_valid & ~sel;
  assign bus0.req_write_i = req_write;
  assign bus0.req_addr_i  = req_addr;
  assign bus0.req_wdata_i = req_wdata;
  assign bus1.req_valid_i = req_valid & sel;
  assign bus1.req_write_i = req_write;
  assign bus1.req_addr_i  = req_addr;
  assign bus1.req_wdata_i = req_wdata;

  spi_boot_master #(.CLK_DIV(DIV0), .DUMMY_CYCLES(DUM0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .spi_clk_o(sclk0), .spi_cs_o(cs0), .spi_sdo0_o(sdo0), .spi_sdi0_i(miso)
  );

  spi_boot_master #(.CLK_DIV(DIV1), .DUMMY_CYCLES(DUM1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .spi_clk_o(sclk1), .spi_cs_o(cs1), .spi_sdo0_o(sdo1), .spi_sdi0_i(miso)
  );

  always #5 clk = ~clk;

  logic        m_sclk, m_cs, m_sdo, m_ready, m_busy, m_rsp_valid;
  logic [31:0] m_rdata;
  assign m_sclk      = sel ? sclk1 : sclk0;
  assign m_cs        = sel ? cs1 : cs0;
  assign m_sdo       = sel ? sdo1 : sdo0;
  assign m_ready     = sel ? bus1.req_ready_o : bus0.req_ready_o;
  assign m_busy      = sel ? bus1.busy_o : bus0.busy_o;
  assign m_rsp_valid = sel ? bus1.rsp_valid_o : bus0.rsp_valid_o;
  assign m_rdata     = sel ? bus1.rsp_rdata_o : bus0.rsp_rdata_o;

  // Slave model / monitor: records MOSI per frame, drives MISO after SCLK falls
  int unsigned cyc = 0, rises = 0, cs_low = 0, rise_cyc = 0, gap = 0;
  int unsigned frames = 0, rsp_total = 0, viol = 0, done_rises = 0, done_cslow = 0;
  logic [127:0] frame_vec = '0, done_vec = '0;
  logic [31:0]  rsp_data = '0, slave_word = '0, sh = '0;
  logic         p_sclk = 1'b0, p_cs = 1'b1, p_sdo = 1'b0;

  always @(negedge clk) begin
    int unsigned dum;
    dum = sel ? DUM1 : DUM0;
    cyc++;
    if (!rst && (m_sdo !== p_sdo) && !(p_sclk && !m_sclk) && !(p_cs && !m_cs)) viol++;
    if (p_cs && !m_cs) begin
      rises = 0; cs_low = 0; frame_vec = '0; gap = cyc - rise_cyc;
    end
    if (!m_cs) cs_low++;
    if (!m_cs && !p_sclk && m_sclk) begin
      frame_vec = {frame_vec[126:0], m_sdo};
      rises++;
    end
    if (!m_cs && p_sclk && !m_sclk && rises >= 40 + dum && rises < 72 + dum) begin
      sh   = slave_word >> (31 - (rises - 40 - dum));
      miso = sh[0];
    end
    if (!p_cs && m_cs) begin
      rise_cyc = cyc; frames++;
      done_vec = frame_vec; done_rises = rises; done_cslow = cs_low;
    end
    if (m_rsp_valid) begin
      rsp_total++;
      rsp_data = m_rdata;
    end
    p_sclk = m_sclk; p_cs = m_cs; p_sdo = m_sdo;
  end

  int unsigned errors = 0, checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (m_ready !== 1'b1 && n < 5000) begin tick(); n++; end
    check("ready_wait", 64'(m_ready), 64'd1);
  endtask

  task automatic wait_frame(input int unsigned f0, input int unsigned nf);
    int unsigned n = 0;
    while (frames - f0 < nf && n < 5000) begin tick(); n++; end
    check("frame_wait", 64'(frames - f0), 64'(nf));
  endtask

  // Frame-level expectations from command/address/data and the slot arithmetic
  task automatic check_frame(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] word);
    int unsigned div, dum, bits;
    logic [7:0]  cmd;
    logic [63:0] mask;
    div  = sel ? DIV1 : DIV0;
    dum  = sel ? DUM1 : DUM0;
    bits = wr ? 72 : 72 + dum;
    cmd  = wr ? 8'h02 : 8'h0B;
    check("mosi_hdr", 64'(40'(done_vec >> (bits - 40))), 64'({cmd, addr}));
    if (wr) check("mosi_wdata", 64'(done_vec[31:0]), 64'(wdata));
    else begin
      mask = (64'd1 << (32 + dum)) - 64'd1;
      check("mosi_rd_tail", done_vec[63:0] & mask, 64'd0);
    end
    check("sclk_rises", 64'(done_rises), 64'(bits));
    check("cs_low_len", 64'(done_cslow), 64'((2 * bits + 1) * div));
    check("rsp_rdata", 64'(rsp_data), wr ? 64'd0 : 64'(word));
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word);
    int unsigned f0, r0, div;
    div = sel ? DIV1 : DIV0;
    slave_word = word;
    wait_ready();
    f0 = frames;
    r0 = rsp_total;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    check("accept_state", 64'({m_ready, m_busy, m_cs, m_sclk, m_sdo}), 64'(5'b01000));
    wait_frame(f0, 1);
    check_frame(wr, addr, wdata, word);
    repeat (div + 2) tick();
    check("rsp_count", 64'(rsp_total - r0), 64'd1);
    check("idle_after", 64'({m_ready, m_busy, m_cs}), 64'(3'b101));
    check("sdo_stable", 64'(viol), 64'd0);
  endtask

  initial begin
    int unsigned f0, r0, n;
    logic [31:0] a0, d0, a1, d1;

    repeat (3) tick();
    sel = 1'b0; #1;
    check("rst_outs0", 64'({m_ready, m_busy, m_rsp_valid, m_sclk, m_cs, m_sdo}), 64'(6'b100010));
    check("rst_rdata0", 64'(m_rdata), 64'd0);
    sel = 1'b1; #1;
    check("rst_outs1", 64'({m_ready, m_busy, m_rsp_valid, m_sclk, m_cs, m_sdo}), 64'(6'b100010));
    sel = 1'b0;
    rst = 1'b0;
    tick();

    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    run_txn(1'b0, 32'h0010_0000, 32'h0, 32'hCAFE_F00D);
    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);

    // Two writes with req_valid held high across both
    a0 = $urandom; d0 = $urandom; a1 = $urandom; d1 = $urandom;
    wait_ready();
    f0 = frames; r0 = rsp_total;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a0; req_wdata = d0;
    tick();
    req_addr = a1; req_wdata = d1;
    wait_frame(f0, 1);
    check_frame(1'b1, a0, d0, 32'h0);
    n = 0;
    while (m_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    check("b2b_accepted", 64'({m_ready, m_busy}), 64'(2'b01));
    wait_frame(f0, 2);
    check("b2b_gap", 64'(gap), 64'(DIV0 + 1));
    check_frame(1'b1, a1, d1, 32'h0);
    repeat (DIV0 + 2) tick();
    check("b2b_rsp", 64'(rsp_total - r0), 64'd2);

    // Reset in the middle of address bit 10
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (rises < 19 && n < 2000) begin tick(); n++; end
    check("rst_reach_addr", 64'(rises), 64'd19);
    r0 = rsp_total;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_pins", 64'({cs0, sclk0}), 64'(2'b10));
    tick();
    check("rst_no_rsp", 64'({rsp_total - r0, 1'(m_rsp_valid)}), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_release", 64'({m_ready, m_busy, m_cs}), 64'(3'b101));
    run_txn(1'b0, $urandom, 32'h0, $urandom);

    // Full-rate instance, writes only
    sel = 1'b1;
    tick();
    run_txn(1'b1, $urandom, $urandom, 32'h0);
    run_txn(1'b1, $urandom, $urandom, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
